kernel_accum: RTL and testbench
===============================

Name: kernel_accum

Overview:
- Consumer end of the per-element adder kernel interface.
- Takes beats of NDATA unsigned magnitudes (|if - w|) plus per-element sign bits.
- Sums each beat through one registered adder-tree stage and accumulates beats over a frame.
- Emits the AdderNet output feature -Σ|x-w| as two's complement, with a count of negative-sign elements, over a valid/ready handshake to the next layer stage.

Parameters:
NBIT, `NBIT, width of one magnitude element (unsigned)
NDATA, `NDATA, elements per beat
ACC_W, 24, result width incl. sign; magnitude saturates at 2^(ACC_W-1)-1
CNT_W, 16, width of negative-sign counter; saturates at 2^CNT_W-1

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  asynchronous active-low reset
i_valid  in  1  input beat valid
o_ready  out  1  block can accept a beat
i_r  in  NBIT*NDATA  magnitudes; element k = i_r[NBIT*k +: NBIT]
i_sign  in  NDATA  sign bit per element (1 = if < w)
i_last  in  1  beat is final beat of frame
o_valid  out  1  result valid
i_ready  in  1  downstream accepts result
o_l1  out  ACC_W  -Σ magnitudes, two's complement
o_neg_cnt  out  CNT_W  number of i_sign bits set in frame
o_sat  out  1  magnitude accumulator saturated during frame

Behaviour:
- Reset (async, i_rstn=0): state IDLE; o_valid=0, o_l1=0, o_neg_cnt=0, o_sat=0, o_ready=1 after release; pipeline valid, accumulators and counters cleared. Reset mid-frame or with a pending result drops it silently.
- Accept rule: a beat transfers on a rising edge with i_valid=1 and o_ready=1. i_r/i_sign/i_last are don't-care otherwise.
- Pipe stage S1, edge of acceptance: register beat sum (width NBIT+clog2(NDATA)), popcount(i_sign) and last flag.
- Pipe stage S2, following edge: add S1 into magnitude and count accumulators.
  - Magnitude add saturates at 2^(ACC_W-1)-1 and sets the sticky sat flag.
  - Count add saturates at 2^CNT_W-1; there is no flag for count saturation.
- FSM states:
  - IDLE: o_ready=1. An accepted beat goes to ACCUM and is the first beat of the frame; accumulators are loaded, not added. An accepted beat with i_last=1 goes directly to DRAIN.
  - ACCUM: o_ready=1. Gaps with i_valid=0 are allowed and do not change state. An accepted beat with i_last=1 goes to DRAIN.
  - DRAIN: o_ready=0. When the last beat has left S2, go to OUT.
  - OUT: o_ready=0, o_valid=1.
    - o_l1 = -(acc magnitude); o_neg_cnt and o_sat hold stable while i_ready=0.
    - On an edge with i_ready=1: o_valid drops, accumulators and sat flag clear, state goes to IDLE, o_ready=1 next cycle.
- Latency: last beat accepted at edge N -> o_valid=1 after edge N+2.
- Throughput: one beat per cycle within a frame. Frame-to-frame gap is at least 3 cycles (drain plus handshake).
- Single-beat frame is legal. A zero-magnitude frame gives o_l1=0.
- o_l1 is registered and not combinational from inputs. o_ready is a decode of state only, not combinational from i_valid.

Decomposition:
- Shared package / Parameter.v additions:
  - ACC_W and CNT_W defaults as `define.
  - State encoding constants: IDLE=2'd0, ACCUM=2'd1, DRAIN=2'd2, OUT=2'd3.
- One sub-module: kernel_sum_tree. It is a combinational adder tree plus popcount of one beat. It is instantiated once, and its outputs are registered in S1 by kernel_accum.

Test Plan (NBIT=8, NDATA=9 unless noted):
- Single beat: all r=10, sign=9'b000000111, last=1 -> o_valid two edges later, o_l1=-90 (24'hFFFFA6), o_neg_cnt=3, o_sat=0.
- 4-beat frame, all r=255, signs all 1, with 2-cycle i_valid gaps between beats -> o_l1=-9180 (24'hFFDC24), o_neg_cnt=36; o_ready stays 1 during gaps.
- Backpressure: hold i_ready=0 for 5 cycles in OUT -> o_valid, o_l1 and o_neg_cnt stable, and o_ready=0 throughout. Raise i_ready -> o_valid=0 and o_ready=1 on the next cycle.
- Saturation (ACC_W=12): one beat all r=255 (sum 2295) -> o_l1=-2047 (12'h801), o_sat=1. The next frame, r=1 -> o_l1=-9, o_sat=0.
- Reset mid-frame: assert i_rstn=0 asynchronously after 2 accepted beats -> all outputs 0 immediately. After release, a 1-beat frame of r=1 gives o_l1=-9, with no residue from the earlier beats.
- Back-to-back frames: the second frame's first beat is presented while the first result is in OUT. It is not accepted until after the handshake, and both results are correct and in order.

Source files
------------

// File: rtl/kernel_accum_pkg.sv
// Shared defaults and FSM state encoding for the adder-kernel accumulator slice.
package kernel_accum_pkg;

    localparam int NBIT_DEF  = 8;
    localparam int NDATA_DEF = 9;
    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

endpackage

// File: rtl/kernel_sum_tree.sv
// Combinational sum of one beat of unsigned magnitudes plus popcount of its sign bits.
module kernel_sum_tree
    import kernel_accum_pkg::*;
#(
    parameter int NBIT  = NBIT_DEF,
    parameter int NDATA = NDATA_DEF
) (
    input  logic [NBIT*NDATA-1:0]          r,
    input  logic [NDATA-1:0]               sign,
    output logic [NBIT+$clog2(NDATA)-1:0]  sum,
    output logic [$clog2(NDATA+1)-1:0]     neg
);

    localparam int SUM_W = NBIT + $clog2(NDATA);
    localparam int PC_W  = $clog2(NDATA + 1);

    // Written as a linear reduction; synthesis balances it into a tree.
    always_comb begin
        sum = '0;
        neg = '0;
        for (int k = 0; k < NDATA; k++) begin
            sum = sum + SUM_W'(r[NBIT*k +: NBIT]);
            neg = neg + PC_W'(sign[k]);
        end
    end

endmodule

// File: rtl/kernel_accum.sv
// Accumulates adder-kernel beats over a frame and emits -sum|x-w| with a negative-sign count.
module kernel_accum
    import kernel_accum_pkg::*;
#(
    parameter int NBIT  = NBIT_DEF,
    parameter int NDATA = NDATA_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [NBIT*NDATA-1:0]  i_r,
    input  logic [NDATA-1:0]       i_sign,
    input  logic                   i_last,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [ACC_W-1:0]       o_l1,
    output logic [CNT_W-1:0]       o_neg_cnt,
    output logic                   o_sat
);

    localparam int SUM_W = NBIT + $clog2(NDATA);
    localparam int PC_W  = $clog2(NDATA + 1);
    localparam int MAG_W = ACC_W - 1;
    localparam int EXT_W = ((MAG_W > SUM_W) ? MAG_W : SUM_W) + 1;
    localparam int CNT_X = CNT_W + 1;
    localparam logic [MAG_W-1:0] MAG_MAX = '1;

    logic [1:0]        state;
    logic              accept;
    logic              handshake;
    logic [SUM_W-1:0]  sum_c;
    logic [PC_W-1:0]   neg_c;

    logic              vld_p1;
    logic              first_p1;
    logic              last_p1;
    logic [SUM_W-1:0]  sum_p1;
    logic [PC_W-1:0]   neg_p1;

    logic              last_vld_p2;
    logic [MAG_W-1:0]  acc_mag_p2;
    logic [CNT_W-1:0]  acc_cnt_p2;
    logic              acc_sat_p2;

    logic [EXT_W-1:0]  mag_in;
    logic [MAG_W:0]    mag_res;
    logic [CNT_X-1:0]  cnt_in;
    logic              sat_nxt;
    logic signed [ACC_W-1:0] l1_neg;

    // Returns {overflow, clamped magnitude}.
    function automatic logic [MAG_W:0] sat_mag(input logic [EXT_W-1:0] v);
        if (v > EXT_W'(MAG_MAX))
            return {1'b1, MAG_MAX};
        else
            return {1'b0, v[MAG_W-1:0]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_X-1:0] v);
        return v[CNT_W] ? {CNT_W{1'b1}} : v[CNT_W-1:0];
    endfunction

    assign o_ready   = (state == IDLE) || (state == ACCUM);
    assign o_valid   = (state == OUT);
    assign accept    = i_valid && o_ready;
    assign handshake = (state == OUT) && i_ready;

    kernel_sum_tree #(
        .NBIT  (NBIT),
        .NDATA (NDATA)
    ) u_sum_tree (
        .r    (i_r),
        .sign (i_sign),
        .sum  (sum_c),
        .neg  (neg_c)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= i_last ? DRAIN : ACCUM;
                ACCUM:   if (accept && i_last) state <= DRAIN;
                DRAIN:   if (last_vld_p2) state <= OUT;
                default: if (i_ready) state <= IDLE;
            endcase
        end
    end

    // ---- S1: register beat sum, popcount and framing flags ----
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
            sum_p1   <= '0;
            neg_p1   <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                first_p1 <= (state == IDLE);
                last_p1  <= i_last;
                sum_p1   <= sum_c;
                neg_p1   <= neg_c;
            end
        end
    end

    assign mag_in  = first_p1 ? EXT_W'(sum_p1) : EXT_W'(acc_mag_p2) + EXT_W'(sum_p1);
    assign mag_res = sat_mag(mag_in);
    assign cnt_in  = first_p1 ? CNT_X'(neg_p1) : CNT_X'(acc_cnt_p2) + CNT_X'(neg_p1);
    assign sat_nxt = (first_p1 ? 1'b0 : acc_sat_p2) | mag_res[MAG_W];

    // ---- S2: saturating accumulate (first beat of a frame loads) ----
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            last_vld_p2 <= 1'b0;
            acc_mag_p2  <= '0;
            acc_cnt_p2  <= '0;
            acc_sat_p2  <= 1'b0;
        end else begin
            last_vld_p2 <= vld_p1 && last_p1;
            if (vld_p1) begin
                acc_mag_p2 <= mag_res[MAG_W-1:0];
                acc_cnt_p2 <= sat_cnt(cnt_in);
                acc_sat_p2 <= sat_nxt;
            end else if (handshake) begin
                acc_mag_p2 <= '0;
                acc_cnt_p2 <= '0;
                acc_sat_p2 <= 1'b0;
            end
        end
    end

    assign l1_neg = -$signed({1'b0, acc_mag_p2});

    // ---- Output register: captured once the last beat has been accumulated ----
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_l1      <= '0;
            o_neg_cnt <= '0;
            o_sat     <= 1'b0;
        end else if ((state == DRAIN) && last_vld_p2) begin
            o_l1      <= l1_neg;
            o_neg_cnt <= acc_cnt_p2;
            o_sat     <= acc_sat_p2;
        end else if (handshake) begin
            o_l1      <= '0;
            o_neg_cnt <= '0;
            o_sat     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kernel_accum.sv
// Directed bench for kernel_accum: a 24-bit result instance and a 12-bit one for saturation.
module tb_kernel_accum;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_valid;
    logic        i_last;
    logic        i_ready;
    logic [71:0] i_r;
    logic [8:0]  i_sign;

    logic        o_ready, o_valid, o_sat;
    logic [23:0] o_l1;
    logic [15:0] o_neg_cnt;

    logic        o_ready_s, o_valid_s, o_sat_s;
    logic [11:0] o_l1_s;
    logic [15:0] o_neg_cnt_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    kernel_accum #(.NBIT(8), .NDATA(9), .ACC_W(24), .CNT_W(16)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_valid(i_valid), .o_ready(o_ready),
        .i_r(i_r), .i_sign(i_sign), .i_last(i_last), .o_valid(o_valid),
        .i_ready(i_ready), .o_l1(o_l1), .o_neg_cnt(o_neg_cnt), .o_sat(o_sat)
    );

    kernel_accum #(.NBIT(8), .NDATA(9), .ACC_W(12), .CNT_W(16)) dut_s (
        .i_clk(clk), .i_rstn(rstn), .i_valid(i_valid), .o_ready(o_ready_s),
        .i_r(i_r), .i_sign(i_sign), .i_last(i_last), .o_valid(o_valid_s),
        .i_ready(i_ready), .o_l1(o_l1_s), .o_neg_cnt(o_neg_cnt_s), .o_sat(o_sat_s)
    );

    // Presents one beat with all nine magnitudes equal; returns 1ns after the accepting edge.
    task automatic send_beat(input logic [7:0] rv, input logic [8:0] sg, input logic last);
        i_r     = {9{rv}};
        i_sign  = sg;
        i_last  = last;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    // Counts falling edges until o_valid rises, giving up after 8.
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!o_valid && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic handshake();
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b0;
        i_r = '0; i_sign = '0;
        repeat (2) @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_l1 !== 24'h0) begin errors++; $display("FAIL reset_l1: got %h want 000000", o_l1); end
        checks++; if (o_neg_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", o_neg_cnt); end
        checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", o_sat); end
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    endtask

    task automatic test_single();
        int cyc;
        send_beat(8'd10, 9'b000000111, 1'b1);
        wait_out(cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL single_latency: got %0d want 3 falling edges", cyc); end
        checks++; if (o_l1 !== 24'hFFFFA6) begin errors++; $display("FAIL single_l1: got %h want FFFFA6", o_l1); end
        checks++; if (o_neg_cnt !== 16'd3) begin errors++; $display("FAIL single_cnt: got %0d want 3", o_neg_cnt); end
        checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL single_sat: got %b want 0", o_sat); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL single_ready_out: got %b want 0", o_ready); end
        handshake();
        @(negedge clk);
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++; $display("FAIL single_release: got valid=%b ready=%b want valid=0 ready=1", o_valid, o_ready);
        end
    endtask

    task automatic test_zero();
        int cyc;
        send_beat(8'd0, 9'b101010101, 1'b1);
        wait_out(cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL zero_latency: got %0d want 3", cyc); end
        checks++; if (o_l1 !== 24'h0 || o_neg_cnt !== 16'd5) begin
            errors++; $display("FAIL zero_result: got l1=%h cnt=%0d want l1=000000 cnt=5", o_l1, o_neg_cnt);
        end
        handshake();
    endtask

    task automatic test_gaps();
        int cyc;
        logic ready_ok;
        ready_ok = 1'b1;
        for (int b = 0; b < 4; b++) begin
            send_beat(8'd255, 9'h1FF, (b == 3));
            if (b < 3) begin
                repeat (2) begin
                    @(negedge clk);
                    if (o_ready !== 1'b1) ready_ok = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
        end
        checks++; if (ready_ok !== 1'b1) begin errors++; $display("FAIL gaps_ready: got 0 during a gap want 1"); end
        wait_out(cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL gaps_latency: got %0d want 3", cyc); end
        checks++; if (o_l1 !== 24'hFFDC24) begin errors++; $display("FAIL gaps_l1: got %h want FFDC24", o_l1); end
        checks++; if (o_neg_cnt !== 16'd36) begin errors++; $display("FAIL gaps_cnt: got %0d want 36", o_neg_cnt); end
        handshake();
    endtask

    task automatic test_backpressure();
        int cyc;
        logic stable_ok;
        stable_ok = 1'b1;
        send_beat(8'd20, 9'h1FF, 1'b1);
        wait_out(cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL bp_latency: got %0d want 3", cyc); end
        repeat (5) begin
            @(negedge clk);
            if (o_valid !== 1'b1 || o_l1 !== 24'hFFFF4C || o_neg_cnt !== 16'd9 || o_ready !== 1'b0)
                stable_ok = 1'b0;
        end
        checks++; if (stable_ok !== 1'b1) begin
            errors++; $display("FAIL bp_hold: got valid=%b l1=%h cnt=%0d ready=%b want 1 FFFF4C 9 0", o_valid, o_l1, o_neg_cnt, o_ready);
        end
        handshake();
        @(negedge clk);
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got valid=%b ready=%b want valid=0 ready=1", o_valid, o_ready);
        end
    endtask

    task automatic test_saturation();
        int cyc;
        send_beat(8'd255, 9'h000, 1'b1);
        wait_out(cyc);
        checks++; if (o_valid_s !== 1'b1) begin errors++; $display("FAIL sat_valid: got %b want 1", o_valid_s); end
        checks++; if (o_l1_s !== 12'h801) begin errors++; $display("FAIL sat_l1: got %h want 801", o_l1_s); end
        checks++; if (o_sat_s !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b want 1", o_sat_s); end
        checks++; if (o_l1 !== 24'hFFF709 || o_sat !== 1'b0) begin
            errors++; $display("FAIL sat_wide: got l1=%h sat=%b want FFF709 0", o_l1, o_sat);
        end
        handshake();
        send_beat(8'd1, 9'h000, 1'b1);
        wait_out(cyc);
        checks++; if (o_l1_s !== 12'hFF7 || o_sat_s !== 1'b0 || o_neg_cnt_s !== 16'd0) begin
            errors++; $display("FAIL sat_next: got l1=%h sat=%b cnt=%0d want FF7 0 0", o_l1_s, o_sat_s, o_neg_cnt_s);
        end
        checks++; if (o_l1 !== 24'hFFFFF7) begin errors++; $display("FAIL sat_next_wide: got %h want FFFFF7", o_l1); end
        handshake();
    endtask

    task automatic test_reset_mid();
        int cyc;
        send_beat(8'd50, 9'h0FF, 1'b0);
        send_beat(8'd50, 9'h0FF, 1'b0);
        #2 rstn = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_l1 !== 24'h0 || o_neg_cnt !== 16'd0 || o_sat !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs: got valid=%b l1=%h cnt=%0d sat=%b want zeros", o_valid, o_l1, o_neg_cnt, o_sat);
        end
        @(negedge clk);
        rstn = 1'b1;
        send_beat(8'd1, 9'h000, 1'b1);
        wait_out(cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL rstmid_latency: got %0d want 3", cyc); end
        checks++; if (o_l1 !== 24'hFFFFF7 || o_neg_cnt !== 16'd0) begin
            errors++; $display("FAIL rstmid_residue: got l1=%h cnt=%0d want FFFFF7 0", o_l1, o_neg_cnt);
        end
        handshake();
        send_beat(8'd7, 9'h1FF, 1'b1);
        wait_out(cyc);
        #2 rstn = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_l1 !== 24'h0 || o_neg_cnt !== 16'd0) begin
            errors++; $display("FAIL rstout_outputs: got valid=%b l1=%h cnt=%0d want 0 000000 0", o_valid, o_l1, o_neg_cnt);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++; $display("FAIL rstout_release: got ready=%b valid=%b want 1 0", o_ready, o_valid);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        send_beat(8'd3, 9'b000000011, 1'b1);
        i_r = {9{8'd4}}; i_sign = 9'b111110000; i_last = 1'b1; i_valid = 1'b1;
        wait_out(cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL b2b_latency1: got %0d want 3", cyc); end
        checks++; if (o_l1 !== 24'hFFFFE5 || o_neg_cnt !== 16'd2) begin
            errors++; $display("FAIL b2b_first: got l1=%h cnt=%0d want FFFFE5 2", o_l1, o_neg_cnt);
        end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL b2b_blocked: got ready=%b want 0", o_ready); end
        handshake();
        @(negedge clk);
        checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: got ready=%b valid=%b want 1 0", o_ready, o_valid);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        wait_out(cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL b2b_latency2: got %0d want 3", cyc); end
        checks++; if (o_l1 !== 24'hFFFFDC || o_neg_cnt !== 16'd5) begin
            errors++; $display("FAIL b2b_second: got l1=%h cnt=%0d want FFFFDC 5", o_l1, o_neg_cnt);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero();
        test_gaps();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
